// File: rtl/ecpu_alu_issuer.sv
// ecpu_alu_issuer: initiator side of the ALU interface.
// Takes one request (opcode + four operands) over valid/ready, drives the ALU
// from registers, waits ALU_LAT edges, captures results and flags, and holds
// them on a valid/ready response port. One operation in flight at a time.
//
// Optional build macro: ECPU_ALU_STICKY_FLAGS_EN
//   defined   -> flag_over_sticky records any overflow until flag_clr
//   undefined -> flag_over_sticky tied low, flag_clr ignored
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. The initiator holds valid and payload
// stable until that edge; ready may depend on state only, never on valid.
module ecpu_alu_issuer #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  input  logic [WIDTH-1:0] req_d,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_p1,
  output logic [WIDTH-1:0] alu_p2,
  output logic [WIDTH-1:0] alu_p3,
  output logic [WIDTH-1:0] alu_p4,
  input  logic [WIDTH-1:0] alu_r1,
  input  logic [WIDTH-1:0] alu_r2,
  input  logic             alu_zero,
  input  logic             alu_over,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r1,
  output logic [WIDTH-1:0] rsp_r2,
  output logic             rsp_zero,
  output logic             rsp_over,
  output logic             busy,
  input  logic             flag_clr,
  output logic             flag_over_sticky
);

  // ALU latency must fit the 4-bit countdown and be at least one edge.
  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
    $error("ecpu_alu_issuer: ALU_LAT=%0d outside legal range 1..15", ALU_LAT);
  end

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_p1_q, alu_p1_d;
  logic [WIDTH-1:0] alu_p2_q, alu_p2_d;
  logic [WIDTH-1:0] alu_p3_q, alu_p3_d;
  logic [WIDTH-1:0] alu_p4_q, alu_p4_d;
  logic [WIDTH-1:0] rsp_r1_q, rsp_r1_d;
  logic [WIDTH-1:0] rsp_r2_q, rsp_r2_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_over_q, rsp_over_d;
  logic             exec_done;

  // Last EXEC cycle: ALU outputs are valid and get sampled at this edge.
  assign exec_done = (state_q == ST_EXEC) && (cnt_q == 4'd0);

  // Next-state and datapath load decisions; every _d defaults to hold.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_op_d   = alu_op_q;
    alu_p1_d   = alu_p1_q;
    alu_p2_d   = alu_p2_q;
    alu_p3_d   = alu_p3_q;
    alu_p4_d   = alu_p4_q;
    rsp_r1_d   = rsp_r1_q;
    rsp_r2_d   = rsp_r2_q;
    rsp_zero_d = rsp_zero_q;
    rsp_over_d = rsp_over_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_op_d = req_op;
          alu_p1_d = req_a;
          alu_p2_d = req_b;
          alu_p3_d = req_c;
          alu_p4_d = req_d;
          cnt_d    = CNT_LOAD;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          rsp_r1_d   = alu_r1;
          rsp_r2_d   = alu_r2;
          rsp_zero_d = alu_zero;
          rsp_over_d = alu_over;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and response registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      alu_op_q   <= '0;
      alu_p1_q   <= '0;
      alu_p2_q   <= '0;
      alu_p3_q   <= '0;
      alu_p4_q   <= '0;
      rsp_r1_q   <= '0;
      rsp_r2_q   <= '0;
      rsp_zero_q <= 1'b0;
      rsp_over_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_op_q   <= alu_op_d;
      alu_p1_q   <= alu_p1_d;
      alu_p2_q   <= alu_p2_d;
      alu_p3_q   <= alu_p3_d;
      alu_p4_q   <= alu_p4_d;
      rsp_r1_q   <= rsp_r1_d;
      rsp_r2_q   <= rsp_r2_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_over_q <= rsp_over_d;
    end
  end

`ifdef ECPU_ALU_STICKY_FLAGS_EN
  logic flag_sticky_q, flag_sticky_d;

  // Sticky overflow: clear request first, a same-cycle overflow sample wins.
  always_comb begin
    flag_sticky_d = flag_sticky_q;
    if (flag_clr) flag_sticky_d = 1'b0;
    if (exec_done && alu_over) flag_sticky_d = 1'b1;
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_sticky_q <= 1'b0;
    else        flag_sticky_q <= flag_sticky_d;
  end

  assign flag_over_sticky = flag_sticky_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr  = flag_clr;
  assign flag_over_sticky = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_op    = alu_op_q;
  assign alu_p1    = alu_p1_q;
  assign alu_p2    = alu_p2_q;
  assign alu_p3    = alu_p3_q;
  assign alu_p4    = alu_p4_q;
  assign rsp_r1    = rsp_r1_q;
  assign rsp_r2    = rsp_r2_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_over  = rsp_over_q;

endmodule

// File: tb/tb_ecpu_alu_issuer.sv
// Directed bench for ecpu_alu_issuer: instance 0 has ALU_LAT=1, instance 1
// has ALU_LAT=3. Each drives a small ALU model: r1=a+b, r2=c^d,
// zero=(r1==0), over=carry out of a+b.
module tb_ecpu_alu_issuer;

`ifdef ECPU_ALU_STICKY_FLAGS_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [7:0] req_op    [2];
  logic [7:0] req_a     [2];
  logic [7:0] req_b     [2];
  logic [7:0] req_c     [2];
  logic [7:0] req_d     [2];
  logic [7:0] alu_op    [2];
  logic [7:0] alu_p1    [2];
  logic [7:0] alu_p2    [2];
  logic [7:0] alu_p3    [2];
  logic [7:0] alu_p4    [2];
  logic [7:0] alu_r1    [2];
  logic [7:0] alu_r2    [2];
  logic       alu_zero  [2];
  logic       alu_over  [2];
  logic [8:0] sum9      [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_r1    [2];
  logic [7:0] rsp_r2    [2];
  logic       rsp_zero  [2];
  logic       rsp_over  [2];
  logic       busy      [2];
  logic       flag_clr  [2];
  logic       flag_stk  [2];

  int n_checks = 0;
  int n_errors = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    assign sum9[g]     = {1'b0, alu_p1[g]} + {1'b0, alu_p2[g]};
    assign alu_r1[g]   = sum9[g][7:0];
    assign alu_r2[g]   = alu_p3[g] ^ alu_p4[g];
    assign alu_zero[g] = (sum9[g][7:0] == 8'h00);
    assign alu_over[g] = sum9[g][8];

    ecpu_alu_issuer #(.WIDTH(8), .OPW(8), .ALU_LAT(LAT)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid[g]),
      .req_ready        (req_ready[g]),
      .req_op           (req_op[g]),
      .req_a            (req_a[g]),
      .req_b            (req_b[g]),
      .req_c            (req_c[g]),
      .req_d            (req_d[g]),
      .alu_op           (alu_op[g]),
      .alu_p1           (alu_p1[g]),
      .alu_p2           (alu_p2[g]),
      .alu_p3           (alu_p3[g]),
      .alu_p4           (alu_p4[g]),
      .alu_r1           (alu_r1[g]),
      .alu_r2           (alu_r2[g]),
      .alu_zero         (alu_zero[g]),
      .alu_over         (alu_over[g]),
      .rsp_valid        (rsp_valid[g]),
      .rsp_ready        (rsp_ready[g]),
      .rsp_r1           (rsp_r1[g]),
      .rsp_r2           (rsp_r2[g]),
      .rsp_zero         (rsp_zero[g]),
      .rsp_over         (rsp_over[g]),
      .busy             (busy[g]),
      .flag_clr         (flag_clr[g]),
      .flag_over_sticky (flag_stk[g])
    );
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_a[i]     = a;
    req_b[i]     = b;
    req_c[i]     = c;
    req_d[i]     = d;
  endtask

  task automatic check_reset(input int i);
    check($sformatf("rst%0d_req_ready", i), 32'(req_ready[i]), 32'd1);
    check($sformatf("rst%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
    check($sformatf("rst%0d_busy", i),      32'(busy[i]),      32'd0);
    check($sformatf("rst%0d_alu_op", i),    32'(alu_op[i]),    32'h00);
    check($sformatf("rst%0d_alu_p1", i),    32'(alu_p1[i]),    32'h00);
    check($sformatf("rst%0d_alu_p2", i),    32'(alu_p2[i]),    32'h00);
    check($sformatf("rst%0d_alu_p3", i),    32'(alu_p3[i]),    32'h00);
    check($sformatf("rst%0d_alu_p4", i),    32'(alu_p4[i]),    32'h00);
    check($sformatf("rst%0d_rsp_r1", i),    32'(rsp_r1[i]),    32'h00);
    check($sformatf("rst%0d_rsp_r2", i),    32'(rsp_r2[i]),    32'h00);
    check($sformatf("rst%0d_rsp_zero", i),  32'(rsp_zero[i]),  32'd0);
    check($sformatf("rst%0d_rsp_over", i),  32'(rsp_over[i]),  32'd0);
    check($sformatf("rst%0d_sticky", i),    32'(flag_stk[i]),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_op[i]    = 8'h00;
      req_a[i]     = 8'h00;
      req_b[i]     = 8'h00;
      req_c[i]     = 8'h00;
      req_d[i]     = 8'h00;
      rsp_ready[i] = 1'b0;
      flag_clr[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset values
    tick();
    check_reset(0);
    check_reset(1);

    // ALU_LAT=1: 0x80+0x80 wraps to zero with carry
    send(0, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80);
    tick();
    req_valid[0] = 1'b0;
    check("l1_alu_p1", 32'(alu_p1[0]), 32'h80);
    check("l1_alu_p2", 32'(alu_p2[0]), 32'h80);
    check("l1_alu_p3", 32'(alu_p3[0]), 32'h80);
    check("l1_alu_p4", 32'(alu_p4[0]), 32'h80);
    check("l1_busy_exec", 32'(busy[0]), 32'd1);
    check("l1_req_ready_exec", 32'(req_ready[0]), 32'd0);
    check("l1_rsp_valid_early", 32'(rsp_valid[0]), 32'd0);
    tick();
    check("l1_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("l1_rsp_r1", 32'(rsp_r1[0]), 32'h00);
    check("l1_rsp_r2", 32'(rsp_r2[0]), 32'h00);
    check("l1_rsp_zero", 32'(rsp_zero[0]), 32'd1);
    check("l1_rsp_over", 32'(rsp_over[0]), 32'd1);
    check("l1_sticky_set", 32'(flag_stk[0]), 32'(STICKY));

    // Backpressure: second request waits while the response is held
    send(0, 8'h3C, 8'h01, 8'h01, 8'h0F, 8'hF0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rsp_r1", 32'(rsp_r1[0]), 32'h00);
      check("bp_rsp_zero", 32'(rsp_zero[0]), 32'd1);
      check("bp_req_ready", 32'(req_ready[0]), 32'd0);
      check("bp_alu_p1_held", 32'(alu_p1[0]), 32'h80);
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    check("bp_rsp_valid_drop", 32'(rsp_valid[0]), 32'd0);
    check("bp_req_ready_back", 32'(req_ready[0]), 32'd1);
    check("bp_rsp_r1_hold", 32'(rsp_r1[0]), 32'h00);
    check("bp_rsp_over_hold", 32'(rsp_over[0]), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    check("bp2_alu_p1", 32'(alu_p1[0]), 32'h01);
    check("bp2_alu_op", 32'(alu_op[0]), 32'h3C);
    check("bp2_busy", 32'(busy[0]), 32'd1);
    tick();
    check("bp2_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("bp2_rsp_r1", 32'(rsp_r1[0]), 32'h02);
    check("bp2_rsp_r2", 32'(rsp_r2[0]), 32'hFF);
    check("bp2_rsp_zero", 32'(rsp_zero[0]), 32'd0);
    check("bp2_rsp_over", 32'(rsp_over[0]), 32'd0);
    check("bp2_sticky_keep", 32'(flag_stk[0]), 32'(STICKY));
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    check("bp2_rsp_valid_drop", 32'(rsp_valid[0]), 32'd0);
    check("bp2_rsp_r1_hold", 32'(rsp_r1[0]), 32'h02);
    check("bp2_rsp_r2_hold", 32'(rsp_r2[0]), 32'hFF);
    check("bp2_busy_idle", 32'(busy[0]), 32'd0);

    // Sticky: clear coinciding with an overflow sample leaves it set
    send(0, 8'h01, 8'h80, 8'h80, 8'h00, 8'h00);
    tick();
    req_valid[0] = 1'b0;
    flag_clr[0]  = 1'b1;
    tick();
    flag_clr[0]  = 1'b0;
    check("stk_rsp_over", 32'(rsp_over[0]), 32'd1);
    check("stk_set_wins", 32'(flag_stk[0]), 32'(STICKY));
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    check("stk_hold", 32'(flag_stk[0]), 32'(STICKY));
    flag_clr[0] = 1'b1;
    tick();
    flag_clr[0] = 1'b0;
    check("stk_cleared", 32'(flag_stk[0]), 32'd0);

    // ALU_LAT=3: response first valid four cycles after acceptance
    send(1, 8'hA5, 8'h01, 8'h02, 8'h55, 8'h0F);
    tick();
    req_valid[1] = 1'b0;
    check("l3_alu_op", 32'(alu_op[1]), 32'hA5);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("l3_busy_c%0d", k), 32'(busy[1]), 32'd1);
      check($sformatf("l3_rsp_valid_c%0d", k), 32'(rsp_valid[1]), 32'd0);
      tick();
    end
    check("l3_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    check("l3_busy_resp", 32'(busy[1]), 32'd1);
    check("l3_rsp_r1", 32'(rsp_r1[1]), 32'h03);
    check("l3_rsp_r2", 32'(rsp_r2[1]), 32'h5A);
    check("l3_rsp_zero", 32'(rsp_zero[1]), 32'd0);
    check("l3_rsp_over", 32'(rsp_over[1]), 32'd0);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    check("l3_rsp_valid_drop", 32'(rsp_valid[1]), 32'd0);
    check("l3_busy_idle", 32'(busy[1]), 32'd0);
    check("l3_req_ready", 32'(req_ready[1]), 32'd1);

    // Reset mid-EXEC aborts the operation asynchronously
    send(1, 8'h11, 8'hFF, 8'h01, 8'h00, 8'h00);
    tick();
    req_valid[1] = 1'b0;
    check("ab_busy_before", 32'(busy[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ab_busy", 32'(busy[1]), 32'd0);
    check("ab_req_ready", 32'(req_ready[1]), 32'd1);
    check("ab_alu_op", 32'(alu_op[1]), 32'h00);
    check("ab_alu_p1", 32'(alu_p1[1]), 32'h00);
    check("ab_rsp_r1", 32'(rsp_r1[1]), 32'h00);
    check("ab_rsp_r2", 32'(rsp_r2[1]), 32'h00);
    check("ab_other_alu_p1", 32'(alu_p1[0]), 32'h00);
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("ab_no_rsp", 32'(rsp_valid[1]), 32'd0);
      check("ab_idle", 32'(busy[1]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ecpu_alu_issuer.md
Name: ecpu_alu_issuer

Overview:
- Initiator side of the ALU interface.
- Accepts one operation request (opcode plus four operands) over a valid/ready handshake and drives the ALU's operation/operand inputs from registers.
- Waits a fixed, parameterised ALU latency, captures both ALU results and the zero/overflow flags, and presents them on a valid/ready response port.
- Sits between the future instruction decoder and the existing ALU; replaces the constant operand drive currently in the top level.

Parameters:
- WIDTH, 8, operand/result width in bits.
- OPW, 8, opcode width in bits.
- ALU_LAT, 1, edges from ALU input update to result sample; legal range 1..15 (1 = combinational ALU).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  issuer can accept a request.
- req_op  input  OPW  opcode.
- req_a, req_b, req_c, req_d  input  WIDTH each  operands 1..4.
- alu_op  output  OPW  registered opcode to ALU.
- alu_p1, alu_p2, alu_p3, alu_p4  output  WIDTH each  registered operands to ALU.
- alu_r1, alu_r2  input  WIDTH each  ALU results.
- alu_zero, alu_over  input  1 each  ALU zero/overflow flags.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer takes response.
- rsp_r1, rsp_r2  output  WIDTH each  captured results.
- rsp_zero, rsp_over  output  1 each  captured flags.
- busy  output  1  high in EXEC or RESP.
- flag_clr  input  1  clear sticky overflow (optional feature).
- flag_over_sticky  output  1  sticky overflow (optional feature).

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous assert, active low; all state is registered.
- Reset values: FSM = IDLE, req_ready = 1, rsp_valid = 0, busy = 0. alu_op, alu_p1..p4, rsp_r1, rsp_r2, rsp_zero, rsp_over, latency counter and flag_over_sticky all = 0.
- FSM states: IDLE, EXEC, RESP.
- req_ready = (state == IDLE), decoded combinationally from state.
- IDLE: when req_valid && req_ready in cycle n:
  - At the end of cycle n, load alu_op and alu_p1..p4 from req_*.
  - Load the counter with ALU_LAT-1.
  - Go to EXEC.
  - req_valid with any other state is ignored; no request is dropped, because ready is low.
- EXEC: decrement the counter each cycle. In the cycle where counter == 0:
  - Sample alu_r1, alu_r2, alu_zero and alu_over into the rsp_* registers.
  - Set rsp_valid and go to RESP.
  - Latency: rsp_valid is first high in cycle n+1+ALU_LAT.
- RESP: hold rsp_* and rsp_valid stable until rsp_ready is high.
  - On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE. req_ready is high the following cycle.
  - No overlap between operations: throughput is one op per ALU_LAT+2 cycles minimum.
- alu_op/alu_p* hold the last issued values after completion; they are not cleared. They change only on acceptance.
- rsp_r*/rsp_* flags keep their last captured value after the handshake; only rsp_valid drops.
- Reset asserted in any state aborts the operation immediately, with all outputs at reset values. No response is produced for the aborted request.
- ALU_LAT outside 1..15 is a configuration error. The implementation flags it with a generate-time $error.
- Counter width is 4 bits.

Optional Feature:
- Macro: ECPU_ALU_STICKY_FLAGS_EN.
- Defined:
  - flag_over_sticky sets at the EXEC sample edge when alu_over == 1.
  - It clears on a cycle with flag_clr == 1.
  - Set and clear in the same cycle: set wins, result = 1.
  - The top level drives the board LED from it.
- Not defined:
  - flag_over_sticky is tied to 0 and flag_clr is ignored.
  - The port list is unchanged in both builds.

Test Plan:
Bench ALU model: r1 = a+b, r2 = c^d, zero = (r1 == 0), over = carry out of a+b.
1. Reset: hold rst_n low, then release -> req_ready = 1, rsp_valid = 0, busy = 0, all alu_*/rsp_* = 0x00.
2. ALU_LAT=1: request op=0x00, a=0x80, b=0x80, c=0x80, d=0x80 accepted in cycle n -> alu_p1..p4 = 0x80 in n+1; rsp_valid in n+2 with rsp_r1 = 0x00, rsp_r2 = 0x00, rsp_zero = 1, rsp_over = 1.
3. Backpressure: rsp_ready held low for 5 cycles after rsp_valid -> rsp_* stable, req_ready = 0, a second req_valid is not accepted. Then rsp_ready = 1 -> rsp_valid = 0 next cycle, and the second request is accepted the cycle after.
4. ALU_LAT=3: a=0x01, b=0x02 accepted in cycle n -> rsp_valid first in n+4, rsp_r1 = 0x03, rsp_zero = 0, rsp_over = 0; busy high cycles n+1..n+4 until the handshake.
5. Reset mid-EXEC (ALU_LAT=3): pull rst_n low one cycle after acceptance -> outputs return to reset values asynchronously, and no rsp_valid pulse occurs after release.
6. With ECPU_ALU_STICKY_FLAGS_EN: 0x80+0x80 sets flag_over_sticky = 1. A following 0x01+0x01 keeps it at 1. flag_clr pulsed at the sample edge of an overflowing op leaves it 1; a later flag_clr alone clears it to 0. Without the macro, it is 0 throughout.
